// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//  - Textual defines: RESET_PC_DEF, NOP_INST, ZERO_WORD and the 2-bit state
//    encodings IFS_IDLE / IFS_FETCH / IFS_HOLD / IFS_DROP.
//  - Package if_fetch_pkg: state enum built on those encodings, word constants
//    and a word-alignment helper.
// Optional feature macro used by the fetch files: IF_ALIGN_CHK_EN.
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define RESET_PC_DEF 32'h0000_0000
`define NOP_INST     32'h0000_0000
`define ZERO_WORD    32'h0000_0000
`define IFS_IDLE     2'd0
`define IFS_FETCH    2'd1
`define IFS_HOLD     2'd2
`define IFS_DROP     2'd3
`endif

package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = `IFS_IDLE,
        ST_FETCH = `IFS_FETCH,
        ST_HOLD  = `IFS_HOLD,
        ST_DROP  = `IFS_DROP
    } ifs_state_e;

    localparam logic [31:0] RESET_PC_VAL = `RESET_PC_DEF;
    localparam logic [31:0] NOP_WORD     = `NOP_INST;
    localparam logic [31:0] ZERO_VAL     = `ZERO_WORD;
    localparam logic [31:0] PC_STEP      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_skid_buf.sv
// fetch_skid_buf: single-entry {pc, inst} holding register for a fetched
// instruction that arrived while the output slot was stalled.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  load                capture load_pc/load_inst, entry becomes full
//  clear               drop the entry (wins over load)
//  load_pc, load_inst  data to capture
//  full                entry holds valid data
//  buf_pc, buf_inst    stored data
module fetch_skid_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        full,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_inst
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full     <= 1'b0;
            buf_pc   <= ZERO_VAL;
            buf_inst <= NOP_WORD;
        end else if (load) begin
            full     <= 1'b1;
            buf_pc   <= load_pc;
            buf_inst <= load_inst;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, drives a variable-latency req/ack instruction memory and
// presents {if_pc, if_inst, if_valid} downstream.
// Optional feature macro: IF_ALIGN_CHK_EN (misaligned redirect reports an
// address error instead of fetching).
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  stall                 downstream cannot accept the presented instruction
//  redirect, redir_pc    one-cycle branch/jump redirect from ID and its target
//  imem_req, imem_addr   fetch request and address
//  imem_ack, imem_rdata  fetch completion and instruction word
//  if_pc, if_inst        presented instruction and its PC
//  if_valid              presented instruction is valid
//  if_adel               presented slot is an address-error-on-fetch
//  dbg_state             current FSM state
// Handshakes: imem_req rises with imem_addr and both stay unchanged until a
// cycle with imem_ack high, which completes the transfer in that cycle; ack
// never arrives in the first cycle of a request. Downstream takes the
// presented instruction in any cycle with if_valid & !stall.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VAL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_adel,
    output logic [1:0]  dbg_state
);

    ifs_state_e  state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] drop_addr;
    logic        drop_load;
    logic        halt_q, halt_d;

    logic        out_load, out_kill;
    logic [31:0] out_pc_n, out_inst_n;
    logic        out_adel_n;

    logic        skid_load, skid_clear, skid_full;
    logic [31:0] skid_pc, skid_inst;

    logic        redir_mis;
    logic [31:0] redir_tgt;
    logic        consume, slot_free;

`ifdef IF_ALIGN_CHK_EN
    assign redir_mis = (redir_pc[1:0] != 2'b00);
    assign redir_tgt = redir_pc;
`else
    // Without the check the low bits are simply dropped; halt_q and if_adel
    // therefore never leave 0.
    logic [1:0] unused_redir_lo;
    assign unused_redir_lo = redir_pc[1:0];
    assign redir_mis = 1'b0;
    assign redir_tgt = word_align(redir_pc);
`endif

    assign consume   = if_valid && !stall;
    assign slot_free = !if_valid || !stall;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_pc   (pc),
        .load_inst (imem_rdata),
        .full      (skid_full),
        .buf_pc    (skid_pc),
        .buf_inst  (skid_inst)
    );

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        halt_d     = halt_q;
        drop_load  = 1'b0;
        out_load   = 1'b0;
        out_kill   = 1'b0;
        out_pc_n   = skid_pc;
        out_inst_n = skid_inst;
        out_adel_n = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (redirect) begin
            pc_d       = redir_tgt;
            out_kill   = 1'b1;
            skid_clear = 1'b1;
            halt_d     = redir_mis;
            unique case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state_d = redir_mis ? ST_IDLE : ST_FETCH;
                    end else begin
                        // Request already on the bus cannot be withdrawn:
                        // keep it alive with its old address and eat the ack.
                        state_d   = ST_DROP;
                        drop_load = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = redir_mis ? ST_IDLE : ST_FETCH;
                    end
                end
                default: begin
                    state_d = redir_mis ? ST_IDLE : ST_FETCH;
                end
            endcase
            if (redir_mis) begin
                out_load   = 1'b1;
                out_pc_n   = redir_pc;
                out_inst_n = NOP_WORD;
                out_adel_n = 1'b1;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // halt_q parks the stage after an address error.
                    if (!halt_q) begin
                        state_d = ST_FETCH;
                    end
                    out_kill = consume;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc + PC_STEP;
                        if (slot_free) begin
                            out_load   = 1'b1;
                            out_pc_n   = pc;
                            out_inst_n = imem_rdata;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end else begin
                        out_kill = consume;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        out_load   = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = halt_q ? ST_IDLE : ST_FETCH;
                    end
                    out_kill = consume;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            drop_addr <= ZERO_VAL;
            halt_q    <= 1'b0;
            if_pc     <= ZERO_VAL;
            if_inst   <= NOP_WORD;
            if_valid  <= 1'b0;
            if_adel   <= 1'b0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            halt_q <= halt_d;
            if (drop_load) begin
                drop_addr <= pc;
            end
            if (out_load) begin
                if_pc    <= out_pc_n;
                if_inst  <= out_inst_n;
                if_valid <= 1'b1;
                if_adel  <= out_adel_n;
            end else if (out_kill) begin
                if_valid <= 1'b0;
                if_adel  <= 1'b0;
            end
        end
    end

    assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
    // In DROP the PC already holds the redirect target; the bus must keep
    // showing the address of the killed request.
    assign imem_addr = (state == ST_DROP) ? drop_addr : pc;
    assign dbg_state = state;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed sequence followed by randomized stall,
// redirect and memory latency, checked against a program-order model of the
// instruction stream (next PC is previous + 4 unless a redirect intervened).
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redir_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_adel;
    logic [1:0]  dbg_state;

    logic        stall2, redirect2, ack2;
    logic [31:0] redir_pc2, rdata2;
    logic        req2, valid2, adel2;
    logic [31:0] addr2, pc2, inst2;
    logic [1:0]  dbg2;

    int checks;
    int failures;
    int consumed;
    int consumed_base;
    int lat_min;
    int lat_max;

    logic [31:0] exp_q[$];
    bit          exp_adel_next;
    bit          exp_dead;

    if_fetch u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redir_pc   (redir_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_valid   (if_valid),
        .if_adel    (if_adel),
        .dbg_state  (dbg_state)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall2),
        .redirect   (redirect2),
        .redir_pc   (redir_pc2),
        .imem_req   (req2),
        .imem_addr  (addr2),
        .imem_ack   (ack2),
        .imem_rdata (rdata2),
        .if_pc      (pc2),
        .if_inst    (inst2),
        .if_valid   (valid2),
        .if_adel    (adel2),
        .dbg_state  (dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score the transfer that the coming edge performs, advance,
    // then apply the redirect (if any) to the model.
    task automatic cyc();
        logic        r;
        logic [31:0] t;
        if (!rst && if_valid && !stall) begin
            consumed++;
            if (exp_dead) begin
                chk("consume_after_adel", {31'b0, if_valid}, 32'd0);
            end else if (exp_adel_next) begin
                chk("adel_pc", if_pc, exp_q[0]);
                chk("adel_inst", if_inst, 32'd0);
                chk("adel_flag", {31'b0, if_adel}, 32'd1);
                exp_adel_next = 1'b0;
                exp_dead      = 1'b1;
            end else begin
                chk("sb_pc", if_pc, exp_q[0]);
                chk("sb_inst", if_inst, mem_word(exp_q[0]));
                chk("sb_adel", {31'b0, if_adel}, 32'd0);
                t = exp_q.pop_front();
                exp_q.push_back(t + 32'd4);
            end
        end
        r = redirect;
        t = redir_pc;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            exp_dead      = 1'b0;
            exp_adel_next = 1'b0;
`ifdef IF_ALIGN_CHK_EN
            if (t[1:0] != 2'b00) exp_adel_next = 1'b1;
            exp_q.push_back(t);
`else
            exp_q.push_back({t[31:2], 2'b00});
`endif
            redirect = 1'b0;
        end
    endtask

    // memory driver: ack at least one cycle after a request is first seen
    initial begin
        logic        busy;
        logic [31:0] mem_addr;
        int          wait_left;
        busy       = 1'b0;
        mem_addr   = 32'd0;
        wait_left  = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy       = 1'b0;
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                if (imem_ack) begin
                    imem_ack   = 1'b0;
                    busy       = 1'b0;
                    imem_rdata = 32'hDEAD_BEEF;
                end
                if (busy) begin
                    chk("req_held", {31'b0, imem_req}, 32'd1);
                    chk("addr_stable", imem_addr, mem_addr);
                    wait_left--;
                    if (wait_left <= 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem_word(mem_addr);
                    end
                end else if (imem_req) begin
                    busy      = 1'b1;
                    mem_addr  = imem_addr;
                    wait_left = $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    initial begin
        checks        = 0;
        failures      = 0;
        consumed      = 0;
        lat_min       = 1;
        lat_max       = 1;
        exp_adel_next = 1'b0;
        exp_dead      = 1'b0;
        exp_q.push_back(32'h0000_0000);
        rst       = 1'b1;
        stall     = 1'b0;
        redirect  = 1'b0;
        redir_pc  = 32'd0;
        stall2    = 1'b0;
        redirect2 = 1'b0;
        redir_pc2 = 32'd0;
        ack2      = 1'b0;
        rdata2    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_adel", {31'b0, if_adel}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        chk("rst2_addr", addr2, 32'hFFFF_FFFC);
        chk("rst2_req", {31'b0, req2}, 32'd0);
        chk("rst2_adel", {31'b0, adel2}, 32'd0);
        chk("rst2_state", {30'b0, dbg2}, {30'b0, ST_IDLE});

        // test 1: ack one cycle after each request
        cyc();
        chk("t1_req0", {31'b0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_addr_w0", addr2, 32'hFFFF_FFFC);
        cyc();
        chk("t1_nvalid", {31'b0, if_valid}, 32'd0);
        ack2   = 1'b1;
        rdata2 = 32'h1234_5678;
        cyc();
        chk("t1_valid0", {31'b0, if_valid}, 32'd1);
        chk("t1_pc0", if_pc, 32'h0);
        chk("t1_inst0", if_inst, mem_word(32'h0));
        chk("t1_addr4", imem_addr, 32'h4);
        // test 5: reset PC at the top of the address space wraps
        chk("t5_pc", pc2, 32'hFFFF_FFFC);
        chk("t5_inst", inst2, 32'h1234_5678);
        chk("t5_valid", {31'b0, valid2}, 32'd1);
        chk("t5_wrap_addr", addr2, 32'h0000_0000);
        ack2 = 1'b0;
        cyc();
        chk("t1_gap", {31'b0, if_valid}, 32'd0);
        cyc();
        chk("t1_valid4", {31'b0, if_valid}, 32'd1);
        chk("t1_pc4", if_pc, 32'h4);
        chk("t1_addr8", imem_addr, 32'h8);

        // test 2: stall while the ack for 0x8 arrives
        stall = 1'b1;
        cyc();
        chk("t2_hold_pc", if_pc, 32'h4);
        cyc();
        chk("t2_req_off", {31'b0, imem_req}, 32'd0);
        chk("t2_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
        chk("t2_still4", if_pc, 32'h4);
        stall = 1'b0;
        cyc();
        chk("t2_pc8", if_pc, 32'h8);
        chk("t2_valid8", {31'b0, if_valid}, 32'd1);
        chk("t2_addrc", imem_addr, 32'hC);

        // test 3: redirect while the request for 0x10 is outstanding
        cyc();
        cyc();
        chk("t3_pcc", if_pc, 32'hC);
        chk("t3_addr10", imem_addr, 32'h10);
        redirect = 1'b1;
        redir_pc = 32'h100;
        cyc();
        chk("t3_drop_state", {30'b0, dbg_state}, {30'b0, ST_DROP});
        chk("t3_drop_addr", imem_addr, 32'h10);
        chk("t3_drop_valid", {31'b0, if_valid}, 32'd0);
        cyc();
        chk("t3_killed", {31'b0, if_valid}, 32'd0);
        chk("t3_new_addr", imem_addr, 32'h100);

        // test 4: redirect in the same cycle as the ack
        cyc();
        redirect = 1'b1;
        redir_pc = 32'h200;
        cyc();
        chk("t4_valid", {31'b0, if_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_req", {31'b0, imem_req}, 32'd1);
        cyc();
        cyc();
        chk("t4_pc200", if_pc, 32'h200);

        // misaligned redirect target
        redirect = 1'b1;
        redir_pc = 32'h102;
`ifdef IF_ALIGN_CHK_EN
        cyc();
        chk("t6_valid", {31'b0, if_valid}, 32'd1);
        chk("t6_adel", {31'b0, if_adel}, 32'd1);
        chk("t6_pc", if_pc, 32'h102);
        chk("t6_inst", if_inst, 32'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_req", {31'b0, imem_req}, 32'd0);
            cyc();
        end
        redirect = 1'b1;
        redir_pc = 32'h400;
        cyc();
        chk("t6_resume_addr", imem_addr, 32'h400);
`else
        cyc();
        chk("al_drop_addr", imem_addr, 32'h204);
        cyc();
        chk("al_addr", imem_addr, 32'h100);
        chk("al_adel", {31'b0, if_adel}, 32'd0);
`endif

        // randomized phase, starting near the top of the address space
        lat_min  = 1;
        lat_max  = 3;
        redirect = 1'b1;
        redir_pc = 32'hFFFF_FFE8;
        cyc();
        consumed_base = consumed;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(99, 0) < 30);
            if ($urandom_range(99, 0) < 4) begin
                redirect = 1'b1;
                redir_pc = $urandom;
                if ($urandom_range(3, 0) == 0) redir_pc = 32'hFFFF_FFE0 | (redir_pc & 32'h1F);
`ifdef IF_ALIGN_CHK_EN
                redir_pc[1:0] = 2'b00;
`endif
            end
            cyc();
        end
        stall = 1'b0;
        chk("progress", {31'b0, (consumed - consumed_base) > 200}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
